led_frame_sequencer: RTL
========================

# led_frame_sequencer

Sequences a full WS2812-style LED strip refresh. On a start pulse it reads each pixel's RGB color from the frame buffer BRAM in address order, reorders the color to GRB wire order, and hands pixels one at a time to led_driver over a valid/ready handshake. It then holds the strip-latch gap. It sits between the button/trigger logic and the frame buffer on one side, and led_driver on the other.

## Interface
Parameters:
- NUM_LEDS, 16, pixels per frame; must be ≥ 2.
- READ_LATENCY, 2, cycles from addr_out change to valid pixel_data_in; must be ≥ 1.
- RESET_CYCLES, 8000, latch-gap length in clk_in cycles (80 µs at 100 MHz).
- Derived: AW = $clog2(NUM_LEDS).

Ports:
- clk_in, input, 1, system clock (100 MHz).
- rst_n_in, input, 1, reset: synchronous, active-low.
- start_in, input, 1, one-cycle frame request (e.g. debounced btn[0]).
- addr_out, output, AW, frame-buffer read address.
- pixel_data_in, input, 24, buffer read data {R[7:0], G[7:0], B[7:0]}.
- color_out, output, 24, pixel to led_driver in {G, R, B} order.
- color_valid_out, output, 1, color_out holds a pixel not yet accepted.
- driver_ready_in, input, 1, led_driver can accept a pixel.
- busy_out, output, 1, frame in progress (any state except IDLE).
- frame_done_out, output, 1, one-cycle pulse at the end of the latch gap.

## Operation
- States: IDLE, FETCH, SEND, LATCH.
- IDLE:
  - On start_in: set addr_out to 0, clear the wait counter, go to FETCH.
- FETCH:
  - Wait counter counts clk_in cycles.
  - In the cycle where the counter reaches READ_LATENCY, register {G, R, B} from pixel_data_in into color_out, then go to SEND.
- SEND:
  - color_valid_out = 1.
  - color_out is stable until a transfer occurs. A transfer is color_valid_out & driver_ready_in in the same cycle.
  - On transfer, if addr_out < NUM_LEDS-1: increment addr_out, clear the wait counter, go to FETCH.
  - On transfer, if addr_out = NUM_LEDS-1: go to LATCH, load the latch counter with 0.
- LATCH:
  - color_valid_out = 0. Counts RESET_CYCLES cycles.
  - On the final count: pulse frame_done_out.
  - Then go to FETCH with addr_out = 0 if a start is pending. Otherwise go to IDLE.
- Pending start:
  - start_in while busy sets a pending flag. Multiple requests coalesce into one.
  - The current frame is never aborted or restarted mid-stream.
  - The flag clears when the new frame begins.
  - start_in in the same cycle LATCH finishes counts as pending, so a new frame follows.
- addr_out holds its value in IDLE and LATCH (last address used). It is never out of range (0..NUM_LEDS-1), with no wrap past NUM_LEDS-1.
- driver_ready_in is ignored outside SEND.
- Reset values (rst_n_in low at a clock edge):
  - State IDLE; addr_out 0; color_out 0.
  - color_valid_out, busy_out, frame_done_out: 0.
  - Pending flag and all counters: 0.
- Reset mid-frame aborts at once. No handshake completes in that cycle.

## Timing
- Everything is registered on the rising edge of clk_in. No combinational path from input to output.
- Frame start:
  - start_in sampled at edge E0 gives busy_out = 1 and addr_out = 0 after E0.
  - color_valid_out = 1 after edge E0 + READ_LATENCY + 1.
- Transfer to next pixel:
  - Transfer at edge Et gives color_valid_out = 0 and addr_out + 1 after Et.
  - Next valid after Et + READ_LATENCY + 1.
- Last transfer to done:
  - Last transfer at Et gives LATCH after Et.
  - frame_done_out is high for exactly the one cycle after edge Et + RESET_CYCLES.
  - busy_out falls after the same edge (IDLE case).
- Minimum frame length with driver always ready: NUM_LEDS·(READ_LATENCY+2) + RESET_CYCLES cycles.

## Test plan
- Reset/idle:
  - Hold rst_n_in low for 5 cycles with start_in = 1 -> all outputs 0, state IDLE.
  - After release, with no start -> outputs stay 0 for 100 cycles.
- Single frame (NUM_LEDS=4, READ_LATENCY=2, RESET_CYCLES=16, driver_ready_in tied 1):
  - Buffer model returns 0xFF0000, 0x00FF00, 0x0000FF, 0x123456.
  - Expect exactly 4 transfers with color_out 0x00FF00, 0xFF0000, 0x0000FF, 0x341256.
  - frame_done_out pulses once, 16 cycles after the last transfer.
- Backpressure:
  - driver_ready_in low for 50 cycles during pixel 1 -> color_valid_out stays high, and color_out and addr_out stay unchanged.
  - Transfer occurs on the first ready cycle. No pixel is lost or duplicated.
- Start during frame:
  - Three start_in pulses during pixel 2 -> exactly one extra frame follows.
  - addr_out returns to 0 directly after frame_done_out. busy_out never drops between frames.
- Start coinciding with end of LATCH -> a second frame begins. frame_done_out pulses once per frame.
- Reset mid-SEND:
  - Assert rst_n_in low while color_valid_out = 1 and driver_ready_in = 1 -> no transfer counted, all outputs 0.
  - A subsequent start_in gives a full 4-pixel frame starting at addr 0.

Source files
------------

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer: walks the frame buffer once per frame request, reorders each
// RGB word to GRB wire order, hands pixels to led_driver over valid/ready, then
// holds the strip-latch gap before reporting frame completion.
module led_frame_sequencer #(
   parameter int unsigned NUM_LEDS     = 16,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned RESET_CYCLES = 8000,
   localparam int unsigned AW          = $clog2(NUM_LEDS)
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   input  logic          start_in,
   output logic [AW-1:0] addr_out,
   input  logic [23:0]   pixel_data_in,
   output logic [23:0]   color_out,
   output logic          color_valid_out,
   input  logic          driver_ready_in,
   output logic          busy_out,
   output logic          frame_done_out
);

   // One counter serves both the read-latency wait and the latch gap.
   localparam int unsigned CNT_MAX = (RESET_CYCLES > READ_LATENCY) ? RESET_CYCLES
                                                                   : READ_LATENCY;
   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_LEDS - 1);
   localparam logic [CW-1:0] FETCH_LAST = CW'(READ_LATENCY);
   localparam logic [CW-1:0] LATCH_LAST = CW'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StSend, StLatch} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [23:0]   color_q, color_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic          done_q, done_d;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         color_q   <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         color_q   <= color_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic: fetch, handshake, latch gap, and coalesced restart requests.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      color_d   = color_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_in) begin
               addr_d  = '0;
               cnt_d   = '0;
               state_d = StFetch;
            end
         end

         StFetch: begin
            pending_d = pending_q | start_in;
            if (cnt_q == FETCH_LAST) begin
               // Buffer word is {R, G, B}; the strip expects {G, R, B}.
               color_d = {pixel_data_in[15:8], pixel_data_in[23:16], pixel_data_in[7:0]};
               state_d = StSend;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         StSend: begin
            pending_d = pending_q | start_in;
            if (driver_ready_in) begin
               cnt_d = '0;
               if (addr_q == LAST_ADDR) begin
                  state_d = StLatch;
               end else begin
                  addr_d  = addr_q + AW'(1);
                  state_d = StFetch;
               end
            end
         end

         StLatch: begin
            if (cnt_q == LATCH_LAST) begin
               done_d    = 1'b1;
               cnt_d     = '0;
               pending_d = 1'b0;
               // A start arriving on this very cycle still queues the next frame.
               if (pending_q || start_in) begin
                  addr_d  = '0;
                  state_d = StFetch;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d     = cnt_q + CW'(1);
               pending_d = pending_q | start_in;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   assign addr_out        = addr_q;
   assign color_out       = color_q;
   assign color_valid_out = (state_q == StSend);
   assign busy_out        = (state_q != StIdle);
   assign frame_done_out  = done_q;

endmodule
